vote_session_ctrl: RTL and testbench



---
 rtl/vote_session_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_vote_session_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/vote_session_ctrl.sv
// Voting-machine session controller: one qualified vote per armed session, saturating tallies.
// Optional session timeout is enabled with `define VOTE_TIMEOUT_EN. The null-vote button port is null_btn because null is reserved in SystemVerilog.
module vote_session_ctrl #(
    parameter int unsigned HOLD_CYCLES    = 3000000,
    parameter int unsigned LED_CYCLES     = 1000000,
    parameter int unsigned TIMEOUT_CYCLES = 30000000,
    parameter int unsigned CTR_W          = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arm,
    input  logic             clr,
    input  logic             button_1,
    input  logic             button_2,
    input  logic             null_btn,
    output logic             busy,
    output logic             led,
    output logic             vote_valid,
    output logic [1:0]       vote_sel,
    output logic             timeout,
    output logic [CTR_W-1:0] ctr1,
    output logic [CTR_W-1:0] ctr2,
    output logic [CTR_W-1:0] ctr3
);

    localparam int unsigned MAX_HL = (HOLD_CYCLES > LED_CYCLES) ? HOLD_CYCLES : LED_CYCLES;
`ifdef VOTE_TIMEOUT_EN
    localparam int unsigned MAX_CYC = (MAX_HL > TIMEOUT_CYCLES) ? MAX_HL : TIMEOUT_CYCLES;
`else
    localparam int unsigned MAX_CYC = MAX_HL;
`endif
    localparam int unsigned CNT_W = $clog2(MAX_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_HOLD,
        S_ACK,
        S_RELEASE
    } state_t;

    state_t           state;
    logic [1:0]       sel;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] led_cnt;
`ifdef VOTE_TIMEOUT_EN
    logic [CNT_W-1:0] sess_cnt;
`endif

    logic [2:0] btns;
    logic [2:0] sel_mask;
    logic [1:0] press_code;
    logic       single_press;
    logic       qualify;
    logic       commit;

    assign btns         = {null_btn, button_2, button_1};
    assign single_press = $onehot(btns);

    function automatic logic [CTR_W-1:0] sat_inc(input logic [CTR_W-1:0] v);
        return (v == {CTR_W{1'b1}}) ? v : v + CTR_W'(1);
    endfunction

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        press_code = 2'd0;
        sel_mask   = 3'b000;
        unique case (btns)
            3'b001:  press_code = 2'd1;
            3'b010:  press_code = 2'd2;
            3'b100:  press_code = 2'd3;
            default: press_code = 2'd0;
        endcase
        unique case (sel)
            2'd1:    sel_mask = 3'b001;
            2'd2:    sel_mask = 3'b010;
            2'd3:    sel_mask = 3'b100;
            default: sel_mask = 3'b000;
        endcase
    end

    // A sample qualifies only when the latched button is the sole button high.
    assign qualify = (state == S_HOLD) && (btns == sel_mask);
    assign commit  = qualify && (hold_cnt + CNT_W'(1) == CNT_W'(HOLD_CYCLES));

    // NOTE: all state and outputs update with non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            sel        <= 2'd0;
            hold_cnt   <= '0;
            led_cnt    <= '0;
            busy       <= 1'b0;
            led        <= 1'b0;
            vote_valid <= 1'b0;
            vote_sel   <= 2'd0;
            timeout    <= 1'b0;
            ctr1       <= '0;
            ctr2       <= '0;
            ctr3       <= '0;
`ifdef VOTE_TIMEOUT_EN
            sess_cnt   <= '0;
`endif
        end else begin
            vote_valid <= 1'b0;
            timeout    <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (clr) begin
                        ctr1 <= '0;
                        ctr2 <= '0;
                        ctr3 <= '0;
                    end
                    if (arm) begin
                        state <= S_ARMED;
                        busy  <= 1'b1;
`ifdef VOTE_TIMEOUT_EN
                        sess_cnt <= '0;
`endif
                    end
                end
                S_ARMED: begin
                    if (single_press) begin
                        sel      <= press_code;
                        hold_cnt <= CNT_W'(1);
                        state    <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (commit) begin
                        unique case (sel)
                            2'd1:    ctr1 <= sat_inc(ctr1);
                            2'd2:    ctr2 <= sat_inc(ctr2);
                            default: ctr3 <= sat_inc(ctr3);
                        endcase
                        vote_valid <= 1'b1;
                        vote_sel   <= sel;
                        led        <= 1'b1;
                        led_cnt    <= CNT_W'(1);
                        hold_cnt   <= '0;
                        state      <= S_ACK;
                    end else if (qualify) begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end else begin
                        hold_cnt <= '0;
                        state    <= S_ARMED;
                    end
                end
                S_ACK: begin
                    if (led_cnt == CNT_W'(LED_CYCLES)) begin
                        led     <= 1'b0;
                        led_cnt <= '0;
                        state   <= S_RELEASE;
                    end else begin
                        led_cnt <= led_cnt + CNT_W'(1);
                    end
                end
                S_RELEASE: begin
                    if (btns == 3'b000) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
`ifdef VOTE_TIMEOUT_EN
            // Later assignments override the case above; a commit on the same edge takes priority.
            if (state == S_ARMED || state == S_HOLD) begin
                sess_cnt <= sess_cnt + CNT_W'(1);
                if (sess_cnt + CNT_W'(1) == CNT_W'(TIMEOUT_CYCLES) && !commit) begin
                    state    <= S_IDLE;
                    busy     <= 1'b0;
                    timeout  <= 1'b1;
                    hold_cnt <= '0;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_vote_session_ctrl.sv
// Self-checking bench for vote_session_ctrl: vector table for one full session plus directed corner-case sequences.
module tb_vote_session_ctrl;

    localparam int unsigned HOLD_CYCLES    = 4;
    localparam int unsigned LED_CYCLES     = 3;
    localparam int unsigned TIMEOUT_CYCLES = 20;
    localparam int unsigned CTR_W          = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             arm = 1'b0;
    logic             clr = 1'b0;
    logic             button_1 = 1'b0;
    logic             button_2 = 1'b0;
    logic             null_btn = 1'b0;
    logic             busy;
    logic             led;
    logic             vote_valid;
    logic [1:0]       vote_sel;
    logic             timeout;
    logic [CTR_W-1:0] ctr1;
    logic [CTR_W-1:0] ctr2;
    logic [CTR_W-1:0] ctr3;

    int n_cmp = 0;
    int n_err = 0;
    int vv_count = 0;
    int to_count = 0;

    vote_session_ctrl #(
        .HOLD_CYCLES   (HOLD_CYCLES),
        .LED_CYCLES    (LED_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CTR_W         (CTR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .arm       (arm),
        .clr       (clr),
        .button_1  (button_1),
        .button_2  (button_2),
        .null_btn  (null_btn),
        .busy      (busy),
        .led       (led),
        .vote_valid(vote_valid),
        .vote_sel  (vote_sel),
        .timeout   (timeout),
        .ctr1      (ctr1),
        .ctr2      (ctr2),
        .ctr3      (ctr3)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       arm, clr, b1, b2, bn;
        logic       busy, led, vv;
        logic [1:0] sel;
        logic [2:0] c1, c2, c3;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive inputs on the falling edge, sample outputs 1 ns after the next rising edge.
    task automatic cyc(input logic a, input logic c, input logic x1, input logic x2, input logic xn);
        @(negedge clk);
        arm = a; clr = c; button_1 = x1; button_2 = x2; null_btn = xn;
        @(posedge clk);
        #1;
        if (vote_valid) vv_count++;
        if (timeout) to_count++;
    endtask

    task automatic wait_idle(input string name, input int bound);
        int n = 0;
        while (busy && n < bound) begin
            cyc(0, 0, 0, 0, 0);
            n++;
        end
        check(name, 32'(busy), 32'd0);
    endtask

    function automatic logic [14:0] outs();
        return {busy, led, vote_valid, vote_sel, ctr1, ctr2, ctr3};
    endfunction

    function automatic vec_t mk(input logic a, c, x1, x2, xn, eb, el, ev,
                                input logic [1:0] es, input logic [2:0] e1, e2, e3);
        vec_t v;
        v.arm = a; v.clr = c; v.b1 = x1; v.b2 = x2; v.bn = xn;
        v.busy = eb; v.led = el; v.vv = ev; v.sel = es; v.c1 = e1; v.c2 = e2; v.c3 = e3;
        return v;
    endfunction

    initial begin
        vec_t tbl[10];
        int   v0;
        int   to_idx;
        logic to_busy;

        // Full button_1 session: press held 6 cycles, commit on the 4th, LED for 3, then release.
        tbl[0] = mk(1, 0, 0, 0, 0, 1, 0, 0, 2'd0, 3'd0, 3'd0, 3'd0);
        tbl[1] = mk(0, 0, 1, 0, 0, 1, 0, 0, 2'd0, 3'd0, 3'd0, 3'd0);
        tbl[2] = mk(0, 0, 1, 0, 0, 1, 0, 0, 2'd0, 3'd0, 3'd0, 3'd0);
        tbl[3] = mk(0, 0, 1, 0, 0, 1, 0, 0, 2'd0, 3'd0, 3'd0, 3'd0);
        tbl[4] = mk(0, 0, 1, 0, 0, 1, 1, 1, 2'd1, 3'd1, 3'd0, 3'd0);
        tbl[5] = mk(0, 0, 1, 0, 0, 1, 1, 0, 2'd1, 3'd1, 3'd0, 3'd0);
        tbl[6] = mk(0, 0, 1, 0, 0, 1, 1, 0, 2'd1, 3'd1, 3'd0, 3'd0);
        tbl[7] = mk(0, 0, 0, 0, 0, 1, 0, 0, 2'd1, 3'd1, 3'd0, 3'd0);
        tbl[8] = mk(0, 0, 0, 0, 0, 0, 0, 0, 2'd1, 3'd1, 3'd0, 3'd0);
        tbl[9] = mk(0, 0, 1, 0, 0, 0, 0, 0, 2'd1, 3'd1, 3'd0, 3'd0);

        #12;
        check("reset_outputs", {17'd0, outs()}, 32'd0);
        check("reset_timeout", 32'(timeout), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 10; i++) begin
            cyc(tbl[i].arm, tbl[i].clr, tbl[i].b1, tbl[i].b2, tbl[i].bn);
            check($sformatf("t1_vec%0d", i), {17'd0, outs()},
                  {17'd0, tbl[i].busy, tbl[i].led, tbl[i].vv, tbl[i].sel, tbl[i].c1, tbl[i].c2, tbl[i].c3});
        end

        // Released press resets the hold count; only the later 4-cycle hold votes.
        v0 = vv_count;
        cyc(1, 0, 0, 0, 0);
        repeat (3) cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);
        check("t2_back_armed", {vote_valid, busy, led}, 3'b010);
        repeat (3) cyc(0, 0, 1, 0, 0);
        check("t2_no_early_vote", 32'(vv_count - v0), 32'd0);
        cyc(0, 0, 1, 0, 0);
        check("t2_commit", {vote_valid, led, vote_sel, ctr1}, {1'b1, 1'b1, 2'd1, 3'd2});
        wait_idle("t2_idle", 10);
        check("t2_one_vote", 32'(vv_count - v0), 32'd1);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 1, 1, 1);
        check("t2_idle_ignores", {busy, ctr1, ctr2, ctr3}, {1'b0, 3'd2, 3'd0, 3'd0});
        check("t2_idle_no_vote", 32'(vv_count - v0), 32'd1);

        // Two buttons together never qualify; dropping one starts a fresh hold.
        v0 = vv_count;
        cyc(1, 0, 0, 0, 0);
        repeat (6) cyc(0, 0, 1, 1, 0);
        check("t3_dual_no_vote", {busy, led, 30'(vv_count - v0)}, {1'b1, 1'b0, 30'd0});
        repeat (3) cyc(0, 0, 1, 0, 0);
        check("t3_not_yet", 32'(vote_valid), 32'd0);
        cyc(0, 0, 1, 0, 0);
        check("t3_commit", {vote_valid, vote_sel, ctr1, ctr2}, {1'b1, 2'd1, 3'd3, 3'd0});
        wait_idle("t3_idle", 10);
        check("t3_one_vote", 32'(vv_count - v0), 32'd1);

        // Eight null sessions: tally saturates at 7 while vote_valid keeps pulsing.
        for (int s = 1; s <= 8; s++) begin
            v0 = vv_count;
            cyc(1, 0, 0, 0, 0);
            repeat (HOLD_CYCLES) cyc(0, 0, 0, 0, 1);
            check($sformatf("t4_commit%0d", s), {vote_valid, led, vote_sel}, {1'b1, 1'b1, 2'd3});
            check($sformatf("t4_ctr3_%0d", s), 32'(ctr3), (s < 7) ? 32'(s) : 32'd7);
            wait_idle($sformatf("t4_idle%0d", s), 10);
            check($sformatf("t4_votes%0d", s), 32'(vv_count - v0), 32'd1);
        end
        check("t4_others", {ctr1, ctr2}, {3'd3, 3'd0});
        cyc(0, 1, 0, 0, 0);
        check("t4_clr", {busy, ctr1, ctr2, ctr3}, {1'b0, 9'd0});

        // button_2 held through commit and ACK: FSM waits in RELEASE, no second vote.
        v0 = vv_count;
        cyc(1, 0, 0, 0, 0);
        repeat (HOLD_CYCLES) cyc(0, 0, 0, 1, 0);
        check("t5_commit", {vote_valid, vote_sel, ctr2}, {1'b1, 2'd2, 3'd1});
        repeat (LED_CYCLES) cyc(0, 0, 0, 1, 0);
        check("t5_led_off", {busy, led}, 2'b10);
        repeat (10) cyc(0, 0, 0, 1, 0);
        check("t5_release_wait", {busy, led, 30'(vv_count - v0)}, {1'b1, 1'b0, 30'd1});
        cyc(0, 0, 0, 0, 0);
        check("t5_idle", {busy, ctr1, ctr2, ctr3}, {1'b0, 3'd0, 3'd1, 3'd0});

`ifdef VOTE_TIMEOUT_EN
        // Armed with no press: timeout pulses on the 20th edge after arm.
        cyc(1, 0, 0, 0, 0);
        to_idx = 0;
        to_busy = 1'b1;
        for (int k = 1; k <= 30 && to_idx == 0; k++) begin
            cyc(0, 0, 0, 0, 0);
            if (timeout) begin
                to_idx = k;
                to_busy = busy;
            end
        end
        check("t6_timeout_cycle", 32'(to_idx), 32'(TIMEOUT_CYCLES));
        check("t6_timeout_busy", 32'(to_busy), 32'd0);
        check("t6_timeout_tally", {ctr1, ctr2, ctr3}, {3'd0, 3'd1, 3'd0});
        cyc(0, 0, 0, 0, 0);
        check("t6_timeout_pulse", {timeout, busy}, 2'b00);
`else
        check("t6_no_timeout", 32'(to_count), 32'd0);
`endif

        // Asynchronous reset mid-HOLD discards the session.
        v0 = vv_count;
        cyc(1, 0, 0, 0, 0);
        repeat (2) cyc(0, 0, 1, 0, 0);
        check("t6_in_hold", 32'(busy), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("t6_reset_outputs", {17'd0, outs()}, 32'd0);
        check("t6_reset_timeout", 32'(timeout), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (HOLD_CYCLES + 2) cyc(0, 0, 1, 0, 0);
        check("t6_after_reset", {busy, ctr1, ctr2, ctr3}, {1'b0, 9'd0});
        check("t6_no_partial_vote", 32'(vv_count - v0), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
